// File: rtl/axi_burst_bridge_if.sv
// AXI3 master-side channel bundle for the burst bridge.
// master = bridge, slave = memory system.
interface axi_burst_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_W-1:0]     awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_burst_bridge.sv
// Bridges an instruction port and a data port onto one AXI3 master.
// One read in flight per port, one write in flight, RAW-safe.
module axi_burst_bridge #(
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int LINE_WORDS = 4,
  parameter int INST_ID    = 0,
  parameter int DATA_ID    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic                inst_burst,
  input  logic [31:0]         inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic                inst_last,
  output logic                inst_err,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [2:0]          data_size,
  input  logic                data_burst,
  input  logic [31:0]         data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic                data_last,
  output logic                data_err,
  output logic [DATA_W-1:0]   data_rdata,
  axi_burst_bridge_if.master  axi
);
  localparam int SB = DATA_W / 8;
  localparam logic [31:0] LMASK = ~32'(LINE_WORDS * SB - 1);
  localparam logic [2:0] WSZ = 3'($clog2(SB));
  localparam logic [7:0] BLEN = 8'(LINE_WORDS - 1);
  localparam logic [ID_W-1:0] IID = ID_W'(INST_ID);
  localparam logic [ID_W-1:0] DID = ID_W'(DATA_ID);

  logic inst_rd_busy, data_rd_busy;
  logic wr_busy, aw_done, w_done, bready_q;
  logic r_hs, r_inst, r_data, inst_fin, data_fin;
  logic b_hs, aw_hs, w_hs, ar_hs;
  logic raw, data_rd_req, rd_ok, wr_ok;
  logic inst_busy_n, data_busy_n;
  logic unused_ok;

  assign unused_ok = ^axi.bid;

  assign r_hs     = axi.rvalid & axi.rready;
  assign r_inst   = r_hs & (axi.rid == IID);
  assign r_data   = r_hs & (axi.rid == DID);
  assign inst_fin = r_inst & axi.rlast;
  assign data_fin = r_data & axi.rlast;
  assign ar_hs    = axi.arvalid & axi.arready;
  assign aw_hs    = axi.awvalid & axi.awready;
  assign w_hs     = axi.wvalid & axi.wready;

  // A data R beat owns data_data_ok this cycle; B waits one cycle.
  assign axi.bready = bready_q & ~r_data;
  assign b_hs       = axi.bvalid & axi.bready;

  assign raw = wr_busy &
    ((data_addr & LMASK) == (axi.awaddr & LMASK));
  assign data_rd_req = data_req & ~data_wr;
  assign rd_ok = data_rd_req & (~data_rd_busy | data_fin) &
    ~axi.arvalid & ~raw;
  assign wr_ok = data_req & data_wr & ~wr_busy;
  assign data_addr_ok = rd_ok | wr_ok;
  assign inst_addr_ok = inst_req & (~inst_rd_busy | inst_fin) &
    ~axi.arvalid & ~data_rd_req;

  assign inst_busy_n = (inst_rd_busy & ~inst_fin) | inst_addr_ok;
  assign data_busy_n = (data_rd_busy & ~data_fin) | rd_ok;

  assign inst_data_ok = r_inst;
  assign inst_last    = r_inst & axi.rlast;
  assign inst_err     = r_inst & (|axi.rresp);
  assign inst_rdata   = r_inst ? axi.rdata : '0;

  assign data_data_ok = r_data | b_hs;
  assign data_last    = r_data ? axi.rlast : b_hs;
  assign data_err     = r_data ? (|axi.rresp) : (b_hs & (|axi.bresp));
  assign data_rdata   = r_data ? axi.rdata : '0;

  assign axi.arburst = 2'b01;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;
  assign axi.awlen   = '0;
  assign axi.awid    = DID;
  assign axi.wid     = DID;
  assign axi.wlast   = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_rd_busy <= 1'b0;
      data_rd_busy <= 1'b0;
      axi.rready   <= 1'b0;
      axi.arvalid  <= 1'b0;
      axi.arid     <= '0;
      axi.araddr   <= '0;
      axi.arlen    <= '0;
      axi.arsize   <= '0;
    end else begin
      inst_rd_busy <= inst_busy_n;
      data_rd_busy <= data_busy_n;
      axi.rready   <= inst_busy_n | data_busy_n;
      if (ar_hs) axi.arvalid <= 1'b0;
      if (rd_ok) begin
        axi.arvalid <= 1'b1;
        axi.arid    <= DID;
        if (data_burst) begin
          axi.araddr <= data_addr & LMASK;
          axi.arlen  <= BLEN;
          axi.arsize <= WSZ;
        end else begin
          axi.araddr <= data_addr;
          axi.arlen  <= '0;
          axi.arsize <= data_size;
        end
      end else if (inst_addr_ok) begin
        axi.arvalid <= 1'b1;
        axi.arid    <= IID;
        axi.araddr  <= inst_burst ? (inst_addr & LMASK) : inst_addr;
        axi.arlen   <= inst_burst ? BLEN : 8'd0;
        axi.arsize  <= WSZ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_busy     <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      bready_q    <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.awaddr  <= '0;
      axi.awsize  <= '0;
      axi.wstrb   <= '0;
      axi.wdata   <= '0;
    end else if (wr_ok) begin
      wr_busy     <= 1'b1;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      axi.awvalid <= 1'b1;
      axi.wvalid  <= 1'b1;
      axi.awaddr  <= data_addr;
      axi.awsize  <= data_size;
      axi.wstrb   <= data_wstrb;
      axi.wdata   <= data_wdata;
    end else begin
      if (aw_hs) begin
        axi.awvalid <= 1'b0;
        aw_done     <= 1'b1;
      end
      if (w_hs) begin
        axi.wvalid <= 1'b0;
        w_done     <= 1'b1;
      end
      if (b_hs) begin
        wr_busy  <= 1'b0;
        bready_q <= 1'b0;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end else if (wr_busy & (aw_done | aw_hs) & (w_done | w_hs)) begin
        bready_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_burst_bridge.sv
// Directed bench for axi_burst_bridge: vector table of data reads
// plus hand-written multi-cycle sequences.
module tb_axi_burst_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_burst;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok, inst_last, inst_err;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr, data_burst;
  logic [2:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok, data_last, data_err;
  logic [31:0] data_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  axi_burst_bridge_if #(.DATA_W(32), .ID_W(4)) axi ();

  axi_burst_bridge #(
    .DATA_W(32), .ID_W(4), .LINE_WORDS(4), .INST_ID(0), .DATA_ID(1)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_burst(inst_burst),
    .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_last(inst_last),
    .inst_err(inst_err), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_burst(data_burst), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_last(data_last), .data_err(data_err),
    .data_rdata(data_rdata),
    .axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        burst;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        err;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic ar_accept();
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    #1 chk("arvalid_drop", axi.arvalid, 0);
  endtask

  task automatic data_read(input vec_t v);
    @(negedge clk);
    data_req = 1; data_wr = 0; data_addr = v.addr;
    data_size = v.size; data_burst = v.burst;
    #1 chk("rd_addr_ok", data_addr_ok, 1);
    @(negedge clk);
    data_req = 0;
    #1;
    chk("arvalid", axi.arvalid, 1);
    chk("araddr", axi.araddr, v.araddr);
    chk("arlen", axi.arlen, v.arlen);
    chk("arsize", axi.arsize, v.arsize);
    chk("arid", axi.arid, 1);
    chk("rready_set", axi.rready, 1);
    ar_accept();
    for (int i = 0; i <= int'(v.arlen); i++) begin
      axi.rvalid = 1; axi.rid = 4'd1;
      axi.rdata = v.rdata + 32'(i); axi.rresp = v.rresp;
      axi.rlast = (i == int'(v.arlen));
      #1;
      chk("d_data_ok", data_data_ok, 1);
      chk("d_rdata", data_rdata, v.rdata + 32'(i));
      chk("d_last", data_last, (i == int'(v.arlen)));
      chk("d_err", data_err, v.err);
      @(negedge clk);
    end
    axi.rvalid = 0; axi.rlast = 0;
    #1;
    chk("d_data_ok_idle", data_data_ok, 0);
    chk("d_rdata_idle", data_rdata, 0);
    chk("rready_clr", axi.rready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'h1000, 3'd2, 1'b0, 32'hDEADBEEF, 2'd0,
              32'h1000, 8'd0, 3'd2, 1'b0};
    vt[1] = '{32'h1236, 3'd1, 1'b0, 32'h00005A5A, 2'd0,
              32'h1236, 8'd0, 3'd1, 1'b0};
    vt[2] = '{32'h4007, 3'd0, 1'b0, 32'h00000077, 2'd2,
              32'h4007, 8'd0, 3'd0, 1'b1};
    vt[3] = '{32'h5018, 3'd0, 1'b1, 32'h00000100, 2'd0,
              32'h5010, 8'd3, 3'd2, 1'b0};
    vt[4] = '{32'h503C, 3'd1, 1'b1, 32'hA0000000, 2'd3,
              32'h5030, 8'd3, 3'd2, 1'b1};

    reset = 1;
    inst_req = 0; inst_burst = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_burst = 0; data_size = 0;
    data_addr = 0; data_wstrb = 0; data_wdata = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rid = 0; axi.rdata = 0;
    axi.rresp = 0; axi.rlast = 0; axi.awready = 0; axi.wready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_d_data_ok", data_data_ok, 0);
    reset = 0;

    for (int k = 0; k < 5; k++) data_read(vt[k]);

    // Instruction burst 0x2014 -> line 0x2010, four beats.
    @(negedge clk);
    inst_req = 1; inst_burst = 1; inst_addr = 32'h2014;
    #1 chk("i_addr_ok", inst_addr_ok, 1);
    @(negedge clk);
    inst_req = 0;
    #1;
    chk("i_araddr", axi.araddr, 32'h2010);
    chk("i_arlen", axi.arlen, 3);
    chk("i_arid", axi.arid, 0);
    ar_accept();
    for (int i = 0; i < 4; i++) begin
      axi.rvalid = 1; axi.rid = 4'd0; axi.rresp = 0;
      axi.rdata = 32'h11110000 + 32'(i); axi.rlast = (i == 3);
      #1;
      chk("i_data_ok", inst_data_ok, 1);
      chk("i_rdata", inst_rdata, 32'h11110000 + 32'(i));
      chk("i_last", inst_last, (i == 3));
      chk("i_no_d_ok", data_data_ok, 0);
      @(negedge clk);
    end
    axi.rvalid = 0; axi.rlast = 0;
    #1 chk("i_idle", inst_data_ok, 0);

    // Same-cycle inst and data read: data wins.
    @(negedge clk);
    inst_req = 1; inst_burst = 0; inst_addr = 32'h2100;
    data_req = 1; data_wr = 0; data_burst = 0; data_size = 3'd2;
    data_addr = 32'h1100;
    #1;
    chk("pri_d_ok", data_addr_ok, 1);
    chk("pri_i_ok", inst_addr_ok, 0);
    @(negedge clk);
    data_req = 0;
    #1;
    chk("pri_arid_d", axi.arid, 1);
    chk("pri_i_wait", inst_addr_ok, 0);
    ar_accept();
    chk("pri_i_now", inst_addr_ok, 1);
    @(negedge clk);
    inst_req = 0;
    #1;
    chk("pri_arid_i", axi.arid, 0);
    chk("pri_araddr_i", axi.araddr, 32'h2100);
    ar_accept();
    axi.rvalid = 1; axi.rid = 4'd1; axi.rlast = 1;
    axi.rdata = 32'h0000D00D; axi.rresp = 0;
    #1 chk("pri_d_beat", data_rdata, 32'h0000D00D);
    @(negedge clk);
    axi.rid = 4'd0; axi.rdata = 32'h00001CE0;
    #1;
    chk("pri_i_beat", inst_rdata, 32'h00001CE0);
    chk("pri_i_last", inst_last, 1);
    @(negedge clk);
    axi.rvalid = 0; axi.rlast = 0;
    #1 chk("pri_rready_clr", axi.rready, 0);

    // RAW: write 0x3000 then read 0x3004, B held back 5 cycles.
    @(negedge clk);
    data_req = 1; data_wr = 1; data_addr = 32'h3000;
    data_size = 3'd2; data_wstrb = 4'hF; data_wdata = 32'hCAFEF00D;
    #1 chk("raw_wr_ok", data_addr_ok, 1);
    @(negedge clk);
    data_wr = 0; data_addr = 32'h3004; data_burst = 0;
    #1;
    chk("raw_awvalid", axi.awvalid, 1);
    chk("raw_wvalid", axi.wvalid, 1);
    chk("raw_awaddr", axi.awaddr, 32'h3000);
    chk("raw_wdata", axi.wdata, 32'hCAFEF00D);
    chk("raw_stall0", data_addr_ok, 0);
    axi.awready = 1; axi.wready = 1;
    @(negedge clk);
    axi.awready = 0; axi.wready = 0;
    #1;
    chk("raw_aw_drop", axi.awvalid, 0);
    chk("raw_w_drop", axi.wvalid, 0);
    chk("raw_bready", axi.bready, 1);
    for (int i = 0; i < 5; i++) begin
      chk("raw_stall", data_addr_ok, 0);
      @(negedge clk);
      #1;
    end
    axi.bvalid = 1; axi.bresp = 0;
    #1;
    chk("raw_b_ok", data_data_ok, 1);
    chk("raw_b_last", data_last, 1);
    chk("raw_b_err", data_err, 0);
    chk("raw_b_stall", data_addr_ok, 0);
    @(negedge clk);
    axi.bvalid = 0;
    #1;
    chk("raw_release", data_addr_ok, 1);
    chk("raw_bready_clr", axi.bready, 0);
    @(negedge clk);
    data_req = 0;
    #1 chk("raw_araddr", axi.araddr, 32'h3004);
    ar_accept();
    axi.rvalid = 1; axi.rid = 4'd1; axi.rlast = 1; axi.rdata = 32'h5;
    @(negedge clk);
    axi.rvalid = 0; axi.rlast = 0;

    // R and B completing together: R first, B next cycle.
    @(negedge clk);
    data_req = 1; data_wr = 1; data_addr = 32'h6000;
    data_wdata = 32'h12345678;
    @(negedge clk);
    data_wr = 0; data_addr = 32'h7000; data_size = 3'd2;
    #1 chk("col_rd_ok", data_addr_ok, 1);
    axi.awready = 1; axi.wready = 1;
    @(negedge clk);
    data_req = 0; axi.awready = 0; axi.wready = 0;
    #1;
    chk("col_bready_up", axi.bready, 1);
    chk("col_arvalid", axi.arvalid, 1);
    ar_accept();
    axi.rvalid = 1; axi.rid = 4'd1; axi.rlast = 1;
    axi.rdata = 32'h00001234; axi.rresp = 0;
    axi.bvalid = 1; axi.bresp = 2'd2;
    #1;
    chk("col_bready_mask", axi.bready, 0);
    chk("col_r_ok", data_data_ok, 1);
    chk("col_r_data", data_rdata, 32'h00001234);
    chk("col_r_err", data_err, 0);
    @(negedge clk);
    axi.rvalid = 0; axi.rlast = 0;
    #1;
    chk("col_bready", axi.bready, 1);
    chk("col_b_ok", data_data_ok, 1);
    chk("col_b_err", data_err, 1);
    chk("col_b_rdata", data_rdata, 0);
    @(negedge clk);
    axi.bvalid = 0; axi.bresp = 0;
    #1 chk("col_idle", data_data_ok, 0);

    // Reset after two of four instruction beats.
    @(negedge clk);
    inst_req = 1; inst_burst = 1; inst_addr = 32'h8000;
    @(negedge clk);
    inst_req = 0;
    #1;
    ar_accept();
    for (int i = 0; i < 2; i++) begin
      axi.rvalid = 1; axi.rid = 4'd0; axi.rlast = 0;
      axi.rdata = 32'h80 + 32'(i);
      @(negedge clk);
    end
    axi.rvalid = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    chk("mid_rready", axi.rready, 0);
    chk("mid_busy", dut.inst_rd_busy, 0);
    chk("mid_arvalid", axi.arvalid, 0);
    for (int i = 0; i < 2; i++) begin
      axi.rvalid = 1; axi.rid = 4'd0; axi.rlast = (i == 1);
      #1 chk("mid_no_ok", inst_data_ok, 0);
      @(negedge clk);
    end
    axi.rvalid = 0; axi.rlast = 0;
    inst_req = 1; inst_burst = 0; inst_addr = 32'h9000;
    #1 chk("mid_new_ok", inst_addr_ok, 1);
    @(negedge clk);
    inst_req = 0;
    #1 chk("mid_new_addr", axi.araddr, 32'h9000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
